irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Interrupt priority controller for the m68k bus.
- Latches edge events from up to 7 peripheral sources (timer overflow, UART, SPI, ...). Source i maps to 68000 level i+1.
- Masks sources, drives the encoded active-low IPL lines to the CPU, and services the CPU interrupt-acknowledge cycle.
- Sits beside the timer and other peripherals on the same 16-bit register bus (uds/lds/rw/ack).

Parameters:
- NSRC, 7, number of interrupt sources (1..7); source i is level i+1; unused levels read 0.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_write  in  16  bus write data
- data_read  out  16  bus read data (registered)
- addr  in  8  byte address; addr[7:1] selects word register
- uds  in  1  upper byte strobe (already qualified by chip select)
- lds  in  1  lower byte strobe (already qualified by chip select)
- rw  in  1  1=read, 0=write
- ack  out  1  bus acknowledge
- irq_in  in  NSRC  source requests, level-sensitive inputs, rising edge captured
- ipl_n  out  3  encoded interrupt level to CPU, active low
- iack  in  1  CPU interrupt-acknowledge cycle active (FC=111 decoded)
- iack_level  in  3  level being acknowledged (A3..A1)
- iack_ack  out  1  autovector request (VPA-equivalent); one-cycle pulse
- iack_vector  out  8  vector number (valid only with feature)

Behaviour:
- Reset values: data_read=0, ack=0, ipl_n=3'b111, iack_ack=0, iack_vector=0.
- Reset also clears pending=0, enable=0, irq_in history=0, vec_base=8'h40, and returns the FSM to IDLE.
- Edge capture: irq_r <= irq_in every cycle. An event is irq_in & ~irq_r; it sets pending[i].
- Registers (word index addr[7:1]):
  - 0 PENDING: read returns {8'd0, 1'b0, pending}. A write with lds is write-1-to-clear on bits [6:0].
  - 1 ENABLE: read/write enable[6:0] on the lds byte.
  - 2 STATUS: read-only; [2:0]=current active level, [10:8]=FSM state.
  - 3 VECBASE: read/write on lds, feature only; otherwise reads 0.
  - Upper bytes read 0; writes to them are ignored. Unmapped addresses read 0 and still ack.
- Bus handshake: ack is registered. It is high in every cycle following a cycle with (uds|lds). data_read is updated in the same edge.
- Priority: active = pending & enable. level = index of highest set bit + 1, else 0. ipl_n <= ~level, registered, giving one cycle latency from pending/enable to pin.
- IACK FSM:
  - IDLE: on iack=1, latch iack_level into lvl_q and go to RESPOND.
  - RESPOND (1 cycle): pulse iack_ack=1 and clear pending[lvl_q-1] if lvl_q is in 1..NSRC. Go to WAIT.
  - WAIT: hold until iack=0, then go to IDLE. iack_ack=0 in this state.
- Spurious acknowledge: the latched level has no pending bit, or is 0. Still pulse iack_ack; pending is unchanged.
- Simultaneous events:
  - A new edge event wins over a W1C clear or an IACK clear of the same bit in the same cycle, so no event is lost.
  - W1C and IACK clear of different bits both take effect.
  - An enable write takes effect on pending the next cycle.
- A level that stays high generates exactly one event. A re-trigger requires a falling edge then a rising edge.
- Reset asserted mid-IACK forces IDLE and drops iack_ack in the next cycle.

Optional Feature:
- IRQ_VECTORED_EN
- Defined: iack_vector = vec_base + lvl_q, driven in RESPOND. A spurious acknowledge gives 8'h18. VECBASE register is live. iack_ack still pulses as the valid strobe.
- Undefined: iack_vector fixed at 0, VECBASE reads 0, and the CPU uses autovectors.

Test Plan:
- Reset, then drive irq_in[0] 0->1 with enable=0 -> PENDING reads 16'h0001, ipl_n stays 3'b111. Write ENABLE=16'h0001 -> ipl_n=3'b110 two cycles later.
- enable=7'h7F; raise irq_in[2] and irq_in[5] together -> ipl_n=3'b001 (level 6). After IACK level 6: pending=0x04 and ipl_n=3'b100.
- IACK with iack_level=3 -> iack_ack is exactly one cycle high, pending[2] is cleared, and the FSM holds WAIT until iack drops.
- Write PENDING=0x0001 in the same cycle as a new irq_in[0] edge -> pending[0] remains 1.
- IACK with iack_level=4 and nothing pending -> iack_ack pulses and pending is unchanged. With IRQ_VECTORED_EN, iack_vector=8'h18.
- With IRQ_VECTORED_EN, write VECBASE=0x60 and run IACK level 2 with pending set -> iack_vector=8'h62. Bus read of VECBASE returns 16'h0060 with ack following the strobe by one cycle.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Register bus bundle shared by the m68k peripherals (16-bit data, byte strobes, registered ack).
interface irq_ctrl_if;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic [7:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic        ack;

  modport master (output data_write, addr, uds, lds, rw, input data_read, ack);
  modport slave  (input data_write, addr, uds, lds, rw, output data_read, ack);
endinterface

// File: rtl/irq_ctrl.sv
// m68k interrupt priority controller: edge capture, masking, IPL encode, IACK service.
// Optional IRQ_VECTORED_EN: vectored acknowledge with a programmable VECBASE register.
//
// state   | meaning
// IDLE    | waiting for an interrupt-acknowledge cycle
// RESPOND | one cycle: pulse iack_ack, clear the acknowledged pending bit
// WAIT    | hold until the CPU drops iack
module irq_ctrl #(
  parameter int NSRC = 7
) (
  input  logic            clk,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] irq_in,
  output logic [2:0]      ipl_n,
  input  logic            iack,
  input  logic [2:0]      iack_level,
  output logic            iack_ack,
  output logic [7:0]      iack_vector
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESPOND = 3'd1,
    S_WAIT    = 3'd2
  } state_t;

  state_t          state, state_nx;
  logic [2:0]      lvl_q;
  logic [NSRC-1:0] irq_r;
  logic [NSRC-1:0] pending, pending_nx;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] evt, active;
  logic [NSRC-1:0] w1c_clr, iack_clr, iack_sel;
  logic            iack_hit;
  logic [2:0]      level;
  logic [6:0]      pend7, en7;
  logic [6:0]      word;
  logic            strobe, wr_lo;
  logic [15:0]     rdata;
  logic            unused_bits;
`ifdef IRQ_VECTORED_EN
  logic [7:0]      vec_base;
`endif

  assign strobe = bus.uds | bus.lds;
  assign wr_lo  = bus.lds & ~bus.rw;
  assign word   = bus.addr[7:1];
  assign evt    = irq_in & ~irq_r;
  assign active = pending & enable;
  assign pend7  = 7'(pending);
  assign en7    = 7'(enable);
  assign unused_bits = &{1'b0, bus.data_write, bus.addr[0]};

  always_comb begin
    level = 3'd0;
    for (int i = 0; i < NSRC; i++) begin
      if (active[i]) level = 3'(i + 1);
    end
  end

  always_comb begin
    iack_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      iack_sel[i] = (lvl_q == 3'(i + 1));
    end
  end

  assign iack_hit = |(pending & iack_sel);

  always_comb begin
    w1c_clr = '0;
    if (wr_lo && word == 7'd0) w1c_clr = bus.data_write[NSRC-1:0];
  end

  always_comb begin
    state_nx    = state;
    iack_ack    = 1'b0;
    iack_clr    = '0;
    iack_vector = 8'h00;
    case (state)
      S_IDLE:    if (iack) state_nx = S_RESPOND;
      S_RESPOND: begin
        iack_ack = 1'b1;
        iack_clr = iack_sel;
`ifdef IRQ_VECTORED_EN
        iack_vector = iack_hit ? (vec_base + {5'd0, lvl_q}) : 8'h18;
`endif
        state_nx = S_WAIT;
      end
      S_WAIT:    if (!iack) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // A fresh edge is ORed in after both clears so a coincident event is never lost.
  assign pending_nx = (pending & ~w1c_clr & ~iack_clr) | evt;

  always_comb begin
    rdata = 16'h0000;
    case (word)
      7'd0: rdata = {8'd0, pend7};
      7'd1: rdata = {8'd0, en7};
      7'd2: rdata = {5'd0, state, 5'd0, level};
`ifdef IRQ_VECTORED_EN
      7'd3: rdata = {8'd0, vec_base};
`endif
      default: rdata = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_r         <= '0;
      pending       <= '0;
      enable        <= '0;
      ipl_n         <= 3'b111;
      bus.ack       <= 1'b0;
      bus.data_read <= 16'h0000;
      state         <= S_IDLE;
      lvl_q         <= 3'd0;
`ifdef IRQ_VECTORED_EN
      vec_base      <= 8'h40;
`endif
    end else begin
      irq_r   <= irq_in;
      pending <= pending_nx;
      ipl_n   <= ~level;
      state   <= state_nx;
      bus.ack <= strobe;
      if (strobe) bus.data_read <= bus.rw ? rdata : 16'h0000;
      if (state == S_IDLE && iack) lvl_q <= iack_level;
      if (wr_lo && word == 7'd1) enable <= bus.data_write[NSRC-1:0];
`ifdef IRQ_VECTORED_EN
      if (wr_lo && word == 7'd3) vec_base <= bus.data_write[7:0];
`endif
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected bus reads and IACK vectors, a monitor checks them.
module tb_irq_ctrl;
  localparam int NSRC = 7;
`ifdef IRQ_VECTORED_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] irq_in;
  logic [2:0]      ipl_n;
  logic            iack;
  logic [2:0]      iack_level;
  logic            iack_ack;
  logic [7:0]      iack_vector;

  irq_ctrl_if bus_if();

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .irq_in      (irq_in),
    .ipl_n       (ipl_n),
    .iack        (iack),
    .iack_level  (iack_level),
    .iack_ack    (iack_ack),
    .iack_vector (iack_vector)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    logic [15:0] val;
    string       nm;
  } bus_exp_t;

  bus_exp_t   bus_q[$];
  logic [7:0] vec_q[$];
  bus_exp_t   mon_e;
  int         total = 0;
  int         bad = 0;
  int         pulses = 0;
  int         exp_pulses = 0;
  logic       prev_ack = 1'b0;

  function automatic logic [7:0] vexp(input logic [7:0] v);
    return VEC ? v : 8'h00;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.ack) begin
      if (bus_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack=1 want no ack");
      end else begin
        mon_e = bus_q.pop_front();
        if (mon_e.chk) check(mon_e.nm, bus_if.data_read, mon_e.val);
      end
    end
    if (iack_ack) begin
      pulses++;
      check("iack_pulse_width", {15'd0, prev_ack}, 16'd0);
      if (vec_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_iack_ack: got pulse want none");
      end else begin
        check("iack_vector", {8'd0, iack_vector}, {8'd0, vec_q.pop_front()});
      end
    end
    prev_ack = iack_ack;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_acc(input logic rd, input logic [7:0] a, input logic [15:0] d,
                         input logic u, input logic l, input bit chk,
                         input logic [15:0] exp, input string nm);
    bus_exp_t e;
    e.chk = chk;
    e.val = exp;
    e.nm  = nm;
    bus_q.push_back(e);
    bus_if.rw         = rd;
    bus_if.addr       = a;
    bus_if.data_write = d;
    bus_if.uds        = u;
    bus_if.lds        = l;
    tick();
    bus_if.uds = 1'b0;
    bus_if.lds = 1'b0;
    bus_if.rw  = 1'b1;
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string nm);
    bus_acc(1'b1, a, 16'h0000, 1'b0, 1'b1, 1'b1, exp, nm);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    bus_acc(1'b0, a, d, 1'b0, 1'b1, 1'b0, 16'h0000, "wr");
  endtask

  task automatic iack_start(input logic [2:0] lvl, input logic [7:0] v);
    vec_q.push_back(v);
    exp_pulses++;
    iack       = 1'b1;
    iack_level = lvl;
    tick();
  endtask

  task automatic iack_begin(input logic [2:0] lvl, input logic [7:0] v);
    iack_start(lvl, v);
    tick();
  endtask

  task automatic iack_end;
    iack = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    irq_in            = '0;
    iack              = 1'b0;
    iack_level        = 3'd0;
    bus_if.data_write = 16'h0000;
    bus_if.addr       = 8'h00;
    bus_if.uds        = 1'b0;
    bus_if.lds        = 1'b0;
    bus_if.rw         = 1'b1;
    repeat (3) tick();
    check("rst_data_read", bus_if.data_read, 16'h0000);
    check("rst_ack", {15'd0, bus_if.ack}, 16'd0);
    check("rst_ipl_n", {13'd0, ipl_n}, 16'h0007);
    check("rst_iack_ack", {15'd0, iack_ack}, 16'd0);
    check("rst_iack_vector", {8'd0, iack_vector}, 16'h0000);
    reset = 1'b0;
    tick();
    rd(8'h04, 16'h0000, "status_reset");
    rd(8'h06, VEC ? 16'h0040 : 16'h0000, "vecbase_reset");

    // masked event, then enable with two-cycle pin latency
    irq_in[0] = 1'b1;
    tick(); tick();
    rd(8'h00, 16'h0001, "pending_masked");
    check("ipl_masked", {13'd0, ipl_n}, 16'h0007);
    wr(8'h02, 16'h0001);
    check("ipl_latency", {13'd0, ipl_n}, 16'h0007);
    tick();
    check("ipl_level1", {13'd0, ipl_n}, 16'h0006);

    // enable register byte lanes
    wr(8'h02, 16'hFFFF);
    rd(8'h02, 16'h007F, "enable_rd");
    bus_acc(1'b0, 8'h02, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, "wr_uds");
    rd(8'h02, 16'h007F, "enable_uds_ignored");
    wr(8'h00, 16'h007F);
    tick(); tick();
    rd(8'h00, 16'h0000, "pending_w1c_level_held");
    check("ipl_after_w1c", {13'd0, ipl_n}, 16'h0007);

    // two sources together, highest wins, then IACK level 6
    irq_in[2] = 1'b1;
    irq_in[5] = 1'b1;
    tick(); tick();
    check("ipl_level6", {13'd0, ipl_n}, 16'h0001);
    iack_begin(3'd6, vexp(8'h46));
    iack_end();
    rd(8'h00, 16'h0004, "pending_after_iack6");
    check("ipl_level3", {13'd0, ipl_n}, 16'h0004);

    // IACK level 3, FSM holds WAIT while iack stays high
    iack_begin(3'd3, vexp(8'h43));
    tick();
    rd(8'h04, 16'h0200, "status_wait");
    tick();
    check("iack_ack_low_in_wait", {15'd0, iack_ack}, 16'd0);
    iack_end();
    rd(8'h04, 16'h0000, "status_idle");
    rd(8'h00, 16'h0000, "pending_after_iack3");
    check("ipl_none", {13'd0, ipl_n}, 16'h0007);

    // new edge coincident with W1C of the same bit
    irq_in[0] = 1'b0;
    tick(); tick();
    irq_in[0] = 1'b1;
    wr(8'h00, 16'h0001);
    rd(8'h00, 16'h0001, "event_beats_w1c");

    // W1C and IACK clear of different bits in the same cycle
    irq_in[1] = 1'b1;
    tick(); tick();
    iack_start(3'd2, vexp(8'h42));
    wr(8'h00, 16'h0001);
    rd(8'h00, 16'h0000, "w1c_and_iack");
    iack_end();

    // spurious acknowledges leave pending alone
    irq_in[0] = 1'b0;
    tick(); tick();
    irq_in[0] = 1'b1;
    tick(); tick();
    iack_begin(3'd4, vexp(8'h18));
    iack_end();
    rd(8'h00, 16'h0001, "spurious_keeps_pending");
    iack_begin(3'd0, vexp(8'h18));
    iack_end();
    rd(8'h00, 16'h0001, "spurious0_keeps_pending");
    check("ipl_level1_again", {13'd0, ipl_n}, 16'h0006);

    // VECBASE and vectored IACK level 2
    wr(8'h06, 16'h0060);
    rd(8'h06, VEC ? 16'h0060 : 16'h0000, "vecbase_rd");
    irq_in[1] = 1'b0;
    tick(); tick();
    irq_in[1] = 1'b1;
    tick(); tick();
    iack_begin(3'd2, vexp(8'h62));
    iack_end();
    rd(8'h00, 16'h0001, "pending_after_iack2");
    rd(8'h20, 16'h0000, "unmapped");

    // reset asserted while the FSM is in RESPOND
    iack_start(3'd1, vexp(8'h61));
    reset = 1'b1;
    tick();
    check("reset_mid_iack", {15'd0, iack_ack}, 16'd0);
    check("ipl_reset", {13'd0, ipl_n}, 16'h0007);
    irq_in = '0;
    iack   = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    rd(8'h04, 16'h0000, "status_after_reset");
    rd(8'h00, 16'h0000, "pending_after_reset");
    rd(8'h06, VEC ? 16'h0040 : 16'h0000, "vecbase_after_reset");

    tick(); tick();
    check("pulse_count", 16'(pulses), 16'(exp_pulses));
    check("bus_q_drained", 16'(bus_q.size()), 16'd0);
    check("vec_q_drained", 16'(vec_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
